// File: rtl/uart_rx_frame_if.sv
// Signal bundle between a serial line/config source and the UART frame receiver.
// Handshake: data_valid is a one-cycle strobe with no ready/backpressure; the consumer must capture P_DATA in that cycle.
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampling UART frame receiver: start, DATA_WIDTH data bits LSB-first, optional parity, stop.
// 2-of-3 majority per bit; byte presented with a one-cycle strobe plus parity/stop error flags.
module uart_rx_frame #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_frame_if.slave rx_if,
  output logic [2:0]     dbg_state
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] EDGE_S0   = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] EDGE_S1   = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] EDGE_S2   = EW'(PRESCALE / 2 + 1);
  localparam logic [EW-1:0] EDGE_DEC  = EW'(PRESCALE / 2 + 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  // Encoding is visible on dbg_state: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [2:0]            samp_q, samp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic rx_s;
  logic maj;
  logic decide;
  logic bit_end;
  logic exp_par;

  assign rx_s    = sync_q[1];
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign decide  = (edge_cnt_q == EDGE_DEC);
  assign bit_end = (edge_cnt_q == EDGE_LAST);
  assign exp_par = par_typ_q ? ~^shift_q : ^shift_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      sync_q       <= 2'b11;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      samp_q       <= 3'b111;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[0], rx_if.RX_IN};
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;

    if (state_q != IDLE) begin
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + 1'b1;
      if (edge_cnt_q == EDGE_S0) samp_d[0] = rx_s;
      if (edge_cnt_q == EDGE_S1) samp_d[1] = rx_s;
      if (edge_cnt_q == EDGE_S2) samp_d[2] = rx_s;
    end

    unique case (state_q)
      IDLE: begin
        // The detection cycle itself is edge 0 of the start bit.
        if (!rx_s) begin
          state_d    = START;
          edge_cnt_d = EW'(1);
          par_en_d   = rx_if.PAR_EN;
          par_typ_d  = rx_if.PAR_TYP;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
        end
      end
      START: begin
        if (decide && maj) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (decide) shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (decide && (maj != exp_par)) par_err_d = 1'b1;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Returning at the decision cycle leaves room for a back-to-back start edge.
        if (decide) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
          stp_err_d  = ~maj;
          if (maj && !par_err_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  assign rx_if.P_DATA     = p_data_q;
  assign rx_if.data_valid = data_valid_q;
  assign rx_if.par_err    = par_err_q;
  assign rx_if.stp_err    = stp_err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: frame table plus hand-written glitch and reset sequences.
// Expected bytes and strobe cycles go into queues when a frame is driven and are popped on data_valid.
module tb_uart_rx_frame;

  localparam int PS = 8;
  localparam int DW = 8;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    logic       par_bit;
    logic       stop_bit;
    bit         glitch3;
    bit         toggle_cfg;
    int         gap;
    bit         exp_valid;
    logic [7:0] exp_pdata;
    logic       exp_par_err;
    logic       exp_stp_err;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [2:0]    dbg_state;
  int            cyc;
  int            checks;
  int            errors;
  logic [DW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  vec_t          vecs[11];

  uart_rx_frame_if #(.DATA_WIDTH(DW)) rx_if ();

  uart_rx_frame #(
    .PRESCALE  (PS),
    .DATA_WIDTH(DW)
  ) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .rx_if    (rx_if),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst_n && rx_if.data_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: data_valid with P_DATA=0x%0h at cycle %0d, expected no strobe",
                 rx_if.P_DATA, cyc);
      end else begin
        logic [DW-1:0] e_data;
        int            e_cyc;
        e_data = exp_q.pop_front();
        e_cyc  = exp_cyc_q.pop_front();
        if (rx_if.P_DATA !== e_data) begin
          errors++;
          $display("FAIL strobe_data: P_DATA=0x%0h, expected 0x%0h", rx_if.P_DATA, e_data);
        end
        checks++;
        if (cyc != e_cyc) begin
          errors++;
          $display("FAIL strobe_cycle: data_valid at cycle %0d, expected %0d", cyc, e_cyc);
        end
      end
    end
  end

  // drivers: all run just after a rising edge
  task automatic hold_rx(input logic b, input int n);
    rx_if.RX_IN = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input vec_t v);
    int lat;
    rx_if.PAR_EN  = v.par_en;
    rx_if.PAR_TYP = v.par_typ;
    if (v.exp_valid) begin
      lat = (9 + (v.par_en ? 1 : 0)) * PS + PS / 2 + 3;
      exp_q.push_back(v.data);
      // detection happens two cycles after the start bit is driven (input synchronizer)
      exp_cyc_q.push_back(cyc + 2 + lat);
    end
    hold_rx(1'b0, PS);
    if (v.toggle_cfg) begin
      rx_if.PAR_EN  = ~v.par_en;
      rx_if.PAR_TYP = ~v.par_typ;
    end
    for (int i = 0; i < DW; i++) begin
      if (v.glitch3 && i == 3) begin
        hold_rx(v.data[i], PS / 2);
        hold_rx(~v.data[i], 1);
        hold_rx(v.data[i], PS / 2 - 1);
      end else begin
        hold_rx(v.data[i], PS);
      end
    end
    if (v.par_en) hold_rx(v.par_bit, PS);
    if (v.stop_bit) begin
      hold_rx(1'b1, PS);
    end else begin
      // low across the sample window only, so the return to IDLE does not see a new start
      hold_rx(1'b0, PS - 2);
      hold_rx(1'b1, 2);
    end
    rx_if.PAR_EN  = v.par_en;
    rx_if.PAR_TYP = v.par_typ;
    hold_rx(1'b1, v.gap);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rx_if.RX_IN   = 1'b1;
    rx_if.PAR_EN  = 1'b0;
    rx_if.PAR_TYP = 1'b0;
    rst_n         = 1'b0;

    //           data   pen   ptyp  pbit  stop  gl  tg  gap valid pdata  pe    se
    vecs[0]  = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 20, 1, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 20, 0, 8'hA5, 1'b1, 1'b0};
    vecs[2]  = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 20, 1, 8'h3C, 1'b0, 1'b0};
    vecs[3]  = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 20, 0, 8'h3C, 1'b0, 1'b1};
    vecs[4]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0,  0, 1, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0,  0, 1, 8'hFF, 1'b0, 1'b0};
    vecs[6]  = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 20, 1, 8'h81, 1'b0, 1'b0};
    vecs[7]  = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 20, 1, 8'h55, 1'b0, 1'b0};
    vecs[8]  = '{8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 20, 1, 8'h96, 1'b0, 1'b0};
    vecs[9]  = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 20, 1, 8'h07, 1'b0, 1'b0};
    vecs[10] = '{8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 20, 0, 8'h07, 1'b1, 1'b0};

    #3;
    check("rst_p_data", 32'(rx_if.P_DATA), 32'h0);
    check("rst_data_valid", 32'(rx_if.data_valid), 32'h0);
    check("rst_par_err", 32'(rx_if.par_err), 32'h0);
    check("rst_stp_err", 32'(rx_if.stp_err), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    hold_rx(1'b1, 10);

    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i]);
      if (vecs[i].gap >= 3) begin
        check($sformatf("vec%0d_p_data", i), 32'(rx_if.P_DATA), 32'(vecs[i].exp_pdata));
        check($sformatf("vec%0d_par_err", i), 32'(rx_if.par_err), 32'(vecs[i].exp_par_err));
        check($sformatf("vec%0d_stp_err", i), 32'(rx_if.stp_err), 32'(vecs[i].exp_stp_err));
      end
    end

    // short low pulse on an idle line: detected, then rejected by the start-bit majority
    rx_if.PAR_EN = 1'b0;
    hold_rx(1'b0, 2);
    hold_rx(1'b1, 3);
    check("glitch_in_start", 32'(dbg_state), 32'h1);
    hold_rx(1'b1, 15);
    check("glitch_back_idle", 32'(dbg_state), 32'h0);
    check("glitch_par_err", 32'(rx_if.par_err), 32'h0);
    check("glitch_stp_err", 32'(rx_if.stp_err), 32'h0);
    check("glitch_p_data", 32'(rx_if.P_DATA), 32'h07);

    // reset in the middle of data bit 4 of a frame
    hold_rx(1'b0, PS);
    for (int i = 0; i < 4; i++) hold_rx(1'b0, PS);
    hold_rx(1'b1, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_p_data", 32'(rx_if.P_DATA), 32'h0);
    check("midrst_data_valid", 32'(rx_if.data_valid), 32'h0);
    check("midrst_par_err", 32'(rx_if.par_err), 32'h0);
    check("midrst_stp_err", 32'(rx_if.stp_err), 32'h0);
    check("midrst_state", 32'(dbg_state), 32'h0);
    rx_if.RX_IN = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    hold_rx(1'b1, 10);
    send_frame('{8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 20, 1, 8'h12, 1'b0, 1'b0});
    check("post_rst_p_data", 32'(rx_if.P_DATA), 32'h12);
    check("post_rst_par_err", 32'(rx_if.par_err), 32'h0);
    check("post_rst_stp_err", 32'(rx_if.stp_err), 32'h0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("pending_strobes", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART frame receiver: the receive-side counterpart of the transmit parity/serializer path.
- Oversamples a serial line and recovers 8-bit frames (start, 8 data LSB-first, optional parity, stop).
- Checks parity (even/odd) and stop bit.
- Presents a parallel byte with a one-cycle valid strobe, plus error flags, to the downstream system controller.

Parameters:
- PRESCALE, 8, CLK cycles per bit; even, >= 6.
- DATA_WIDTH, 8, data bits per frame.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line, idle high, asynchronous to CLK.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even, 1 = odd.
- P_DATA  output  DATA_WIDTH  last correctly received byte.
- data_valid  output  1  one-cycle strobe; P_DATA updated this cycle.
- par_err  output  1  parity mismatch in the last frame.
- stp_err  output  1  stop bit sampled low in the last frame.

Behaviour:
- Reset (RST low, async):
  - P_DATA=0, data_valid=0, par_err=0, stp_err=0.
  - FSM=IDLE, counters=0.
  - Synchronizer flops preset to 1.
  - Reset mid-frame aborts the frame with no strobe.
- Input synchronizer:
  - RX_IN passes through a 2-flop synchronizer; rx_s is its output.
  - All timing below is relative to rx_s.
- Counters:
  - edge_cnt runs 0..PRESCALE-1 within a bit.
  - bit_cnt runs 0..DATA_WIDTH-1 in DATA.
- Sampling:
  - Three samples are taken at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The bit value is the 2-of-3 majority, valid at edge_cnt = PRESCALE/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE:
    - rx_s==0 -> START with edge_cnt=1 (the detection cycle counts as edge 0).
    - PAR_EN and PAR_TYP are latched in this cycle; changes mid-frame are ignored.
    - par_err and stp_err are cleared in this cycle.
  - START:
    - If the majority sample is 1 (glitch) -> IDLE at the decision cycle, no flags.
    - Otherwise -> DATA when edge_cnt==PRESCALE-1.
  - DATA:
    - Shift the majority into the shift register LSB-first at the decision cycle.
    - After bit_cnt==DATA_WIDTH-1 and edge_cnt==PRESCALE-1: go to PARITY if the latched PAR_EN is 1, else STOP.
  - PARITY:
    - Expected bit = ^data for even (PAR_TYP=0), ~^data for odd (PAR_TYP=1).
    - A mismatch sets par_err at the decision cycle.
    - -> STOP when edge_cnt==PRESCALE-1.
  - STOP:
    - At the decision cycle, a majority of 0 sets stp_err.
    - FSM -> IDLE on the next cycle; this early return allows back-to-back frames.
- data_valid:
  - Pulses high for exactly one cycle, on the cycle after the stop decision, only if par_err==0 and stp_err==0.
  - P_DATA is loaded from the shift register on that same edge.
  - Latency: data_valid is high (9+P)*PRESCALE + PRESCALE/2 + 3 cycles after the IDLE detection cycle, where P = latched PAR_EN.
- Error frames:
  - P_DATA holds its previous value.
  - Error flags stay asserted until the next start detection.
- Line held low after a stop error (break): the FSM re-enters START immediately and the glitch/abort rules apply.
- With PAR_EN=0, par_err is never set.

Test Plan:
- PRESCALE=8, PAR_EN=1, PAR_TYP=0: frame 0xA5 with parity 0 and stop 1 -> data_valid one cycle at detection+87, P_DATA=0xA5, par_err=0, stp_err=0.
- Same frame with parity bit 1 -> par_err=1, no data_valid, P_DATA keeps 0xA5 from the prior frame; par_err clears at the next start.
- PAR_TYP=1, frame 0x3C with parity 1 -> valid; then 0x3C with stop bit 0 -> stp_err=1, no strobe.
- PAR_EN=0: back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three strobes, 79 cycles from each detection (PAR_EN=0, PRESCALE=8), P_DATA in order.
- Glitch tests:
  - 2-cycle low pulse on idle RX_IN -> FSM returns to IDLE, no strobe, no flags.
  - Single-cycle inverted glitch at mid-bit of data bit 3 of 0x55 -> majority recovers 0x55.
- Reset and config tests:
  - RST low during DATA bit 4 -> all outputs 0 immediately; the next full frame 0x12 is received correctly.
  - Toggling PAR_EN mid-frame has no effect on the frame in progress.
